// File: rtl/spi_flash_read_seq.sv
// Flash READ sequencer: drives the SPI byte CSR handshake (cmd, 24-bit address, N data bytes)
// and streams received bytes as little-endian 16-bit Ufi words. Define SPI_FLASH_FAST_READ_EN for 0x0B + dummy byte.
module spi_flash_read_seq #(
   parameter int unsigned pBusAdrsBit  = 16,
   parameter int unsigned pUfiBusWidth = 16,
   parameter int unsigned pDivClk      = 16,
   parameter int unsigned pLenBits     = 16,
   parameter int unsigned pCsGap       = 4
) (
   input  logic                    iSysClk,
   input  logic                    iSysRst,
   input  logic                    iStart,
   input  logic                    iAbort,
   input  logic [23:0]             iFlashAdrs,
   input  logic [pLenBits-1:0]     iLength,
   input  logic [pBusAdrsBit-1:0]  iDstAdrs,
   input  logic [pDivClk-1:0]      iDiv,
   output logic                    oBusy,
   output logic                    oDone,
   output logic                    oAborted,
   output logic                    oSPIEn,
   output logic [pDivClk-1:0]      oSPIDiv,
   output logic [7:0]              oMWd,
   output logic                    oMSPICs,
   output logic                    oByteReq,
   input  logic                    iByteDone,
   input  logic [7:0]              iMRd,
   output logic [pUfiBusWidth-1:0] oMUfiWd,
   output logic [pBusAdrsBit-1:0]  oMUfiAdrs,
   output logic                    oMUfiEd,
   output logic                    oMUfiVd
);

   localparam int unsigned GapW = (pCsGap > 1) ? $clog2(pCsGap) : 1;
   localparam logic [GapW-1:0] GapLoad = GapW'(pCsGap - 1);
`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] CmdByte = 8'h0B;
`else
   localparam logic [7:0] CmdByte = 8'h03;
`endif

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_CMD,
      ST_ADR2,
      ST_ADR1,
      ST_ADR0,
`ifdef SPI_FLASH_FAST_READ_EN
      ST_DUMMY,
`endif
      ST_DATA,
      ST_CS_HOLD,
      ST_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [GapW-1:0]         gap_q, gap_d;
   logic [pLenBits-1:0]     len_q, len_d;
   logic [23:0]             fadr_q, fadr_d;
   logic [pBusAdrsBit-1:0]  wadr_q, wadr_d;
   logic [pDivClk-1:0]      div_q, div_d;
   logic                    busy_q, busy_d;
   logic                    spi_en_q, spi_en_d;
   logic                    done_q, done_d;
   logic                    aborted_q, aborted_d;
   logic                    cs_n_q, cs_n_d;
   logic [7:0]              mwd_q, mwd_d;
   logic                    byte_req_q, byte_req_d;
   logic                    inflight_q, inflight_d;
   logic                    abort_q, abort_d;
   logic [7:0]              lo_q, lo_d;
   logic                    half_q, half_d;
   logic [pUfiBusWidth-1:0] ufi_wd_q, ufi_wd_d;
   logic [pBusAdrsBit-1:0]  ufi_adrs_q, ufi_adrs_d;
   logic                    ufi_ed_q, ufi_ed_d;
   logic                    ufi_vd_q, ufi_vd_d;

   logic byte_ack;
   logic abort_req;

   // A completion only counts while our own request is outstanding.
   assign byte_ack  = inflight_q & iByteDone;
   assign abort_req = abort_q | iAbort;

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      len_d      = len_q;
      fadr_d     = fadr_q;
      wadr_d     = wadr_q;
      div_d      = div_q;
      busy_d     = busy_q;
      spi_en_d   = spi_en_q;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      cs_n_d     = cs_n_q;
      mwd_d      = mwd_q;
      byte_req_d = 1'b0;
      inflight_d = inflight_q;
      abort_d    = abort_q;
      lo_d       = lo_q;
      half_d     = half_q;
      ufi_wd_d   = ufi_wd_q;
      ufi_adrs_d = ufi_adrs_q;
      ufi_ed_d   = 1'b0;
      ufi_vd_d   = ufi_vd_q;

      if (byte_ack) begin
         inflight_d = 1'b0;
      end
      if (state_q != ST_IDLE && state_q != ST_DONE && iAbort) begin
         abort_d = 1'b1;
      end
      if (state_q != ST_DATA) begin
         ufi_vd_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               fadr_d   = iFlashAdrs;
               len_d    = iLength;
               wadr_d   = iDstAdrs;
               div_d    = iDiv;
               busy_d   = 1'b1;
               spi_en_d = 1'b1;
               abort_d  = 1'b0;
               half_d   = 1'b0;
               if (iLength == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CS_SETUP;
                  cs_n_d  = 1'b0;
                  gap_d   = GapLoad;
               end
            end
         end
         ST_CS_SETUP: begin
            if (abort_req) begin
               state_d = ST_CS_HOLD;
               gap_d   = GapLoad;
            end else if (gap_q == '0) begin
               state_d    = ST_CMD;
               mwd_d      = CmdByte;
               byte_req_d = 1'b1;
               inflight_d = 1'b1;
            end else begin
               gap_d = gap_q - GapW'(1);
            end
         end
         ST_CMD: begin
            if (byte_ack) begin
               if (abort_req) begin
                  state_d = ST_CS_HOLD;
                  gap_d   = GapLoad;
               end else begin
                  state_d    = ST_ADR2;
                  mwd_d      = fadr_q[23:16];
                  byte_req_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
         end
         ST_ADR2: begin
            if (byte_ack) begin
               if (abort_req) begin
                  state_d = ST_CS_HOLD;
                  gap_d   = GapLoad;
               end else begin
                  state_d    = ST_ADR1;
                  mwd_d      = fadr_q[15:8];
                  byte_req_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
         end
         ST_ADR1: begin
            if (byte_ack) begin
               if (abort_req) begin
                  state_d = ST_CS_HOLD;
                  gap_d   = GapLoad;
               end else begin
                  state_d    = ST_ADR0;
                  mwd_d      = fadr_q[7:0];
                  byte_req_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
         end
         ST_ADR0: begin
            if (byte_ack) begin
               if (abort_req) begin
                  state_d = ST_CS_HOLD;
                  gap_d   = GapLoad;
               end else begin
`ifdef SPI_FLASH_FAST_READ_EN
                  state_d    = ST_DUMMY;
`else
                  state_d    = ST_DATA;
                  ufi_vd_d   = 1'b1;
`endif
                  mwd_d      = 8'h00;
                  byte_req_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
         end
`ifdef SPI_FLASH_FAST_READ_EN
         // Dummy byte: response is dropped, only the clocks matter to the flash.
         ST_DUMMY: begin
            if (byte_ack) begin
               if (abort_req) begin
                  state_d = ST_CS_HOLD;
                  gap_d   = GapLoad;
               end else begin
                  state_d    = ST_DATA;
                  ufi_vd_d   = 1'b1;
                  mwd_d      = 8'h00;
                  byte_req_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
         end
`endif
         ST_DATA: begin
            if (byte_ack) begin
               len_d = len_q - pLenBits'(1);
               // Little-endian packing; an odd tail is flushed unless the run was aborted.
               if (!half_q) begin
                  lo_d   = iMRd;
                  half_d = 1'b1;
                  if (len_q == pLenBits'(1) && !abort_req) begin
                     ufi_ed_d   = 1'b1;
                     ufi_wd_d   = pUfiBusWidth'({8'h00, iMRd});
                     ufi_adrs_d = wadr_q;
                     wadr_d     = wadr_q + pBusAdrsBit'(1);
                  end
               end else begin
                  half_d     = 1'b0;
                  ufi_ed_d   = 1'b1;
                  ufi_wd_d   = pUfiBusWidth'({iMRd, lo_q});
                  ufi_adrs_d = wadr_q;
                  wadr_d     = wadr_q + pBusAdrsBit'(1);
               end
               if (len_q == pLenBits'(1) || abort_req) begin
                  state_d = ST_CS_HOLD;
                  gap_d   = GapLoad;
               end else begin
                  mwd_d      = 8'h00;
                  byte_req_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
         end
         ST_CS_HOLD: begin
            if (gap_q == '0) begin
               cs_n_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               gap_d = gap_q - GapW'(1);
            end
         end
         ST_DONE: begin
            done_d    = 1'b1;
            aborted_d = abort_q;
            busy_d    = 1'b0;
            spi_en_d  = 1'b0;
            half_d    = 1'b0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iSysClk) begin
      if (!iSysRst) begin
         state_q    <= ST_IDLE;
         gap_q      <= '0;
         len_q      <= '0;
         fadr_q     <= '0;
         wadr_q     <= '0;
         div_q      <= '0;
         busy_q     <= 1'b0;
         spi_en_q   <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         cs_n_q     <= 1'b1;
         mwd_q      <= '0;
         byte_req_q <= 1'b0;
         inflight_q <= 1'b0;
         abort_q    <= 1'b0;
         lo_q       <= '0;
         half_q     <= 1'b0;
         ufi_wd_q   <= '0;
         ufi_adrs_q <= '0;
         ufi_ed_q   <= 1'b0;
         ufi_vd_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         len_q      <= len_d;
         fadr_q     <= fadr_d;
         wadr_q     <= wadr_d;
         div_q      <= div_d;
         busy_q     <= busy_d;
         spi_en_q   <= spi_en_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         cs_n_q     <= cs_n_d;
         mwd_q      <= mwd_d;
         byte_req_q <= byte_req_d;
         inflight_q <= inflight_d;
         abort_q    <= abort_d;
         lo_q       <= lo_d;
         half_q     <= half_d;
         ufi_wd_q   <= ufi_wd_d;
         ufi_adrs_q <= ufi_adrs_d;
         ufi_ed_q   <= ufi_ed_d;
         ufi_vd_q   <= ufi_vd_d;
      end
   end

   assign oBusy     = busy_q;
   assign oDone     = done_q;
   assign oAborted  = aborted_q;
   assign oSPIEn    = spi_en_q;
   assign oSPIDiv   = div_q;
   assign oMWd      = mwd_q;
   assign oMSPICs   = cs_n_q;
   assign oByteReq  = byte_req_q;
   assign oMUfiWd   = ufi_wd_q;
   assign oMUfiAdrs = ufi_adrs_q;
   assign oMUfiEd   = ufi_ed_q;
   assign oMUfiVd   = ufi_vd_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq: SPI byte-slave model plus MOSI/Ufi scoreboards.
module tb_spi_flash_read_seq;

   localparam int unsigned CS_GAP = 4;
   localparam int          SL_LAT = 3;
`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0]  CMD = 8'h0B;
   localparam int          HDR = 5;
`else
   localparam logic [7:0]  CMD = 8'h03;
   localparam int          HDR = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, abort, byte_done;
   logic [23:0] flash_adrs;
   logic [15:0] length, dst, div;
   logic [7:0]  mrd;
   logic        busy, done, aborted, spi_en, cs_n, byte_req, ufi_ed, ufi_vd;
   logic [15:0] spi_div, ufi_wd, ufi_adrs;
   logic [7:0]  mwd;

   always #5 clk = ~clk;

   spi_flash_read_seq #(
      .pBusAdrsBit(16), .pUfiBusWidth(16), .pDivClk(16), .pLenBits(16), .pCsGap(CS_GAP)
   ) dut (
      .iSysClk(clk), .iSysRst(rst_n), .iStart(start), .iAbort(abort),
      .iFlashAdrs(flash_adrs), .iLength(length), .iDstAdrs(dst), .iDiv(div),
      .oBusy(busy), .oDone(done), .oAborted(aborted), .oSPIEn(spi_en),
      .oSPIDiv(spi_div), .oMWd(mwd), .oMSPICs(cs_n), .oByteReq(byte_req),
      .iByteDone(byte_done), .iMRd(mrd), .oMUfiWd(ufi_wd), .oMUfiAdrs(ufi_adrs),
      .oMUfiEd(ufi_ed), .oMUfiVd(ufi_vd)
   );

   int          checks = 0, errors = 0;
   int          cyc_n = 0, sl_cnt = 0;
   int          txn_req = 0, done_cnt = 0, cs_edges = 0;
   int          t_start, t_cs_fall, t_cs_rise, t_first_req, t_last_bd, t_done;
   logic        last_aborted = 1'b0;
   logic        cs_prev = 1'b1;
   logic [7:0]  miso_q [$];
   logic [7:0]  mosi_exp [$];
   logic [31:0] ufi_exp [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: slave responds SL_LAT cycles after each request; scoreboards sample at negedge.
   task automatic tick();
      logic [7:0]  e8;
      logic [31:0] e32;
      @(negedge clk);
      cyc_n++;
      byte_done = 1'b0;
      if (sl_cnt > 0) begin
         sl_cnt--;
         if (sl_cnt == 0) begin
            byte_done = 1'b1;
            if (miso_q.size() > 0) mrd = miso_q.pop_front();
            else mrd = 8'hEE;
            t_last_bd = cyc_n;
         end
      end
      if (byte_req === 1'b1) begin
         check("req_overlap", 32'(sl_cnt), 32'd0);
         check("req_expected", 32'(mosi_exp.size() != 0), 32'd1);
         if (mosi_exp.size() != 0) begin
            e8 = mosi_exp.pop_front();
            check("mosi_byte", 32'(mwd), 32'(e8));
         end
         check("vd_at_req", 32'(ufi_vd), 32'(txn_req >= HDR));
         txn_req++;
         if (txn_req == 1) t_first_req = cyc_n;
         sl_cnt = SL_LAT;
      end
      if (ufi_ed === 1'b1) begin
         check("ufi_expected", 32'(ufi_exp.size() != 0), 32'd1);
         if (ufi_exp.size() != 0) begin
            e32 = ufi_exp.pop_front();
            check("ufi_word", {ufi_adrs, ufi_wd}, e32);
         end
         check("vd_at_ed", 32'(ufi_vd), 32'd1);
      end
      if (done === 1'b1) begin
         done_cnt++;
         last_aborted = aborted;
         t_done = cyc_n;
      end
      if (cs_n !== cs_prev) begin
         cs_edges++;
         if (cs_n === 1'b0) t_cs_fall = cyc_n;
         else t_cs_rise = cyc_n;
         cs_prev = cs_n;
      end
   endtask

   task automatic setup_read(input logic [23:0] fa, input int len, input logic [15:0] da,
                             input logic [7:0] base, input int n_xfer, input int n_wr);
      logic [7:0]  d [$];
      logic [7:0]  lo, hi;
      logic [15:0] a;
      miso_q.delete(); mosi_exp.delete(); ufi_exp.delete();
      for (int i = 0; i < len; i++) d.push_back(base + 8'(i * 17));
      for (int i = 0; i < HDR; i++) miso_q.push_back(8'h5A);
      for (int i = 0; i < len; i++) miso_q.push_back(d[i]);
      mosi_exp.push_back(CMD);
      mosi_exp.push_back(fa[23:16]);
      mosi_exp.push_back(fa[15:8]);
      mosi_exp.push_back(fa[7:0]);
      if (HDR == 5) mosi_exp.push_back(8'h00);
      for (int i = 0; i < n_xfer; i++) mosi_exp.push_back(8'h00);
      for (int w = 0; w < n_wr; w++) begin
         lo = d[2*w];
         hi = (2*w + 1 < len) ? d[2*w+1] : 8'h00;
         a  = da + 16'(w);
         ufi_exp.push_back({a, hi, lo});
      end
      flash_adrs = fa;
      length     = 16'(len);
      dst        = da;
      txn_req = 0; cs_edges = 0;
      t_cs_fall = -1; t_cs_rise = -1; t_first_req = -1; t_done = -1;
   endtask

   task automatic pulse_start();
      t_start = cyc_n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int base;
      base = done_cnt;
      for (int i = 0; i < budget && done_cnt == base; i++) tick();
      check(tag, 32'(done_cnt - base), 32'd1);
      for (int i = 0; i < 6; i++) tick();
      check({tag, "_single_done"}, 32'(done_cnt - base), 32'd1);
      check({tag, "_mosi_left"}, 32'(mosi_exp.size()), 32'd0);
      check({tag, "_ufi_left"}, 32'(ufi_exp.size()), 32'd0);
   endtask

   task automatic wait_reqs(input int n, input int budget);
      for (int i = 0; i < budget && txn_req < n; i++) tick();
      check("req_reached", 32'(txn_req), 32'(n));
   endtask

   initial begin
      int base;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_done = 1'b0; mrd = 8'h00;
      flash_adrs = '0; length = '0; dst = '0; div = 16'h0007;
      repeat (3) tick();
      check("rst_cs", 32'(cs_n), 32'd1);
      check("rst_busy_done_en", {29'd0, busy, done, spi_en}, 32'd0);
      check("rst_req_ed_vd", {29'd0, byte_req, ufi_ed, ufi_vd}, 32'd0);
      check("rst_div_mwd", {8'd0, spi_div, mwd}, 32'd0);
      check("rst_ufi", {ufi_adrs, ufi_wd}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic read
      setup_read(24'h123456, 4, 16'h0100, 8'hAA, 4, 2);
      pulse_start();
      check("basic_busy", {30'd0, busy, spi_en}, 32'd3);
      check("basic_div", 32'(spi_div), 32'h7);
      wait_done("basic_done", 300);
      check("basic_aborted", 32'(last_aborted), 32'd0);
      check("basic_cs_fall", 32'(t_cs_fall - t_start), 32'd1);
      check("basic_first_req", 32'(t_first_req - t_start), 32'(1 + CS_GAP));
      check("basic_cs_rise", 32'(t_cs_rise - t_last_bd), 32'(CS_GAP + 1));
      check("basic_done_lat", 32'(t_done - t_cs_rise), 32'd1);
      check("basic_cs_edges", 32'(cs_edges), 32'd2);
      check("basic_idle", {30'd0, busy, spi_en}, 32'd0);

      // Odd length: tail word padded with 0x00
      setup_read(24'h000010, 3, 16'h0200, 8'h11, 3, 2);
      pulse_start();
      wait_done("odd_done", 300);
      check("odd_aborted", 32'(last_aborted), 32'd0);

      // Zero length: no CS activity, no requests
      setup_read(24'h000020, 0, 16'h0300, 8'h00, 0, 0);
      mosi_exp.delete();
      pulse_start();
      wait_done("zero_done", 20);
      check("zero_done_lat", 32'(t_done - t_start), 32'd2);
      check("zero_reqs", 32'(txn_req), 32'd0);
      check("zero_cs_edges", 32'(cs_edges), 32'd0);

      // Abort during the 2nd data byte: it completes and finishes word 0
      setup_read(24'h0A0B0C, 8, 16'h0400, 8'h30, 2, 1);
      pulse_start();
      wait_reqs(HDR + 2, 200);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("abort_done", 300);
      check("abort_flag", 32'(last_aborted), 32'd1);
      check("abort_reqs", 32'(txn_req), 32'(HDR + 2));
      check("abort_cs_rise", 32'(t_cs_rise - t_last_bd), 32'(CS_GAP + 1));
      check("abort_done_lat", 32'(t_done - t_cs_rise), 32'd1);

      // Destination wrap, plus a start pulse while busy that must be ignored
      setup_read(24'h400000, 4, 16'hFFFF, 8'h50, 4, 2);
      pulse_start();
      repeat (3) tick();
      flash_adrs = 24'hABCDEF; length = 16'd1; dst = 16'h1234;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("wrap_done", 300);
      check("wrap_aborted", 32'(last_aborted), 32'd0);

      // Reset mid-DATA: CS released on the next edge, no oDone afterwards
      setup_read(24'h777777, 8, 16'h0500, 8'h60, 2, 0);
      pulse_start();
      wait_reqs(HDR + 2, 200);
      base = done_cnt;
      rst_n = 1'b0;
      sl_cnt = 0;
      tick();
      check("rst_mid_cs", 32'(cs_n), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (25) tick();
      check("rst_mid_no_done", 32'(done_cnt - base), 32'd0);
      check("rst_mid_reqs", 32'(txn_req), 32'(HDR + 2));
      check("rst_mid_mosi_left", 32'(mosi_exp.size()), 32'd0);

      // Recovery read after reset
      setup_read(24'hA2A1A0, 2, 16'h0600, 8'h70, 2, 1);
      pulse_start();
      wait_done("post_rst_done", 300);
      check("post_rst_first_req", 32'(t_first_req - t_start), 32'(1 + CS_GAP));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_flash_read_seq.md
# spi_flash_read_seq

Sequencer that drives the SPI unit's byte-level CSR interface to perform a complete flash READ transaction (command, 24-bit address, N data bytes) without CPU involvement. It sits beside the SPI block in the Processor subsystem and replaces per-byte CSR writes. Received bytes are packed into bus words and streamed out on a Ufi master write port, for example for asset loads into VRAM.

## Interface
- pBusAdrsBit, 16, Ufi destination address width
- pUfiBusWidth, 16, Ufi data width; must be 16 (2 bytes per word)
- pDivClk, 16, SCK divider width, passed through to the SPI unit
- pLenBits, 16, byte-count width
- pCsGap, 4, idle cycles for CS setup and CS hold (min 1)

Ports:
- iSysClk  in  1  system clock
- iSysRst  in  1  reset; **synchronous, active-low**
- iStart  in  1  1-cycle start pulse; sampled only in IDLE
- iAbort  in  1  level; requests early termination
- iFlashAdrs  in  24  flash start byte address
- iLength  in  pLenBits  data bytes to read
- iDstAdrs  in  pBusAdrsBit  first Ufi word address
- iDiv  in  pDivClk  SCK divider, latched at start
- oBusy  out  1  high from the accepted start until DONE
- oDone  out  1  1-cycle completion pulse
- oAborted  out  1  valid with oDone; 1 = terminated by iAbort
- oSPIEn  out  1  SPI unit enable
- oSPIDiv  out  pDivClk  latched divider
- oMWd  out  8  byte to shift out
- oMSPICs  out  1  chip select, 0 = asserted
- oByteReq  out  1  1-cycle pulse that starts one byte exchange
- iByteDone  in  1  SPI unit byte-complete pulse (from oMSpiIntr)
- iMRd  in  8  received byte, valid with iByteDone
- oMUfiWd  out  pUfiBusWidth  packed data word
- oMUfiAdrs  out  pBusAdrsBit  word address
- oMUfiEd  out  1  1-cycle word write strobe
- oMUfiVd  out  1  high during the DATA phase

## Operation
- Reset values:
  - oMSPICs = 1.
  - All other outputs = 0.
  - The state machine is in IDLE.
- Reset mid-transaction returns to IDLE on the next edge. CS deasserts immediately and no oDone is issued.
- State machine: IDLE → CS_SETUP → CMD → ADR2 → ADR1 → ADR0 → [DUMMY] → DATA → CS_HOLD → DONE → IDLE.
- IDLE:
  - On iStart: latch all inputs, set oBusy and oSPIEn.
  - If iLength = 0: go directly to DONE with no CS assertion and no byte requests.
- CS_SETUP: assert oMSPICs = 0, then count pCsGap cycles.
- Byte states:
  - Present oMWd and pulse oByteReq once.
  - Wait for iByteDone, then advance.
  - CMD sends 0x03. ADR2, ADR1 and ADR0 send address bits [23:16], [15:8] and [7:0].
  - DATA sends 0x00 per byte and captures iMRd.
- Only one byte may be in flight. The next oByteReq comes no earlier than the cycle after iByteDone. iByteDone outside a wait is ignored.
- Packing is little-endian:
  - The first byte of a pair goes to [7:0] and the second to [15:8].
  - oMUfiEd pulses on the cycle after the second byte's iByteDone.
  - oMUfiAdrs starts at iDstAdrs and increments by 1 per word, wrapping modulo 2^pBusAdrsBit.
- Odd length: the final partial word is emitted with [15:8] = 0x00, one cycle after the last iByteDone.
- The byte counter decrements per data byte. At 0, go to CS_HOLD: count pCsGap cycles, then set oMSPICs = 1.
- DONE:
  - Pulse oDone; clear oBusy and oSPIEn.
  - Return to IDLE on the next cycle.
- iStart while oBusy = 1 is ignored.
- iAbort:
  - Sampled in any non-IDLE state. No new oByteReq is issued.
  - An in-flight byte is allowed to complete. A pending partial word is discarded.
  - The sequence then proceeds through CS_HOLD to DONE with oAborted = 1.
- iAbort in the same cycle as iStart: iStart is accepted, and the abort applies from the next cycle.

## Timing
- Start to CS assertion: 1 cycle (iStart at cycle t, oMSPICs = 0 at t+1).
- First oByteReq occurs at t+1+pCsGap.
- oByteReq follows the preceding iByteDone by exactly 1 cycle.
- Ufi write latency: 1 cycle after the completing iByteDone.
- Last iByteDone to oMSPICs = 1: pCsGap+1 cycles. oDone follows one cycle later.
- iLength = 0: oDone at t+2, and oMSPICs never toggles.
- oMUfiVd rises with the first DATA oByteReq and falls with the last oMUfiEd.

## Configuration
- SPI_FLASH_FAST_READ_EN:
  - Defined: CMD sends 0x0B and the DUMMY state sends one 0x00 byte whose received data is discarded.
  - Undefined: CMD sends 0x03, the DUMMY state does not exist, and ADR0 goes straight to DATA.

## Test plan
- Basic read: iFlashAdrs = 0x123456, iLength = 4, iDstAdrs = 0x0100, model returns AA BB CC DD.
  - MOSI bytes are 03 12 34 56 00 00 00 00.
  - Ufi writes are 0xBBAA@0x0100 and 0xDDCC@0x0101.
  - oDone fires once with oAborted = 0.
- Odd length: iLength = 3, data 11 22 33 → writes 0x2211@dst and 0x0033@dst+1.
- Zero length: iLength = 0 → oDone at t+2, no oByteReq, oMSPICs stays 1.
- Abort: iAbort raised during the 2nd data byte of an 8-byte read.
  - That byte completes; no further oByteReq.
  - Only words already complete are written.
  - CS deasserts after pCsGap+1 cycles; oDone fires with oAborted = 1.
- Address wrap and robustness: iDstAdrs = 0xFFFF, iLength = 4 → writes at 0xFFFF then 0x0000.
  - iStart pulsed while busy is ignored.
  - Reset asserted mid-DATA → oMSPICs = 1 on the next edge, and no oDone is issued.
- With SPI_FLASH_FAST_READ_EN defined: iLength = 2 → MOSI is 0B A2 A1 A0 00 00 00, and the dummy-byte response is not written to the Ufi bus.
